// File: rtl/down_counter.sv
// down_counter: loadable down counter/timer with one-shot or auto-reload expiry,
// registered done/underflow pulses one cycle after the expiring edge.
module down_counter #(
  parameter int DECREMENT_RATE = 1,
  parameter int WIDTH          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             periodic,
  input  logic             stop,
  output logic [WIDTH-1:0] count_val,
  output logic             running,
  output logic             done,
  output logic             underflow
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] count_q, reload_q;
  logic             per_q, done_q, uf_q;
  logic [WIDTH:0]   diff_d;
  logic             expire_d;
  always_comb begin
    diff_d   = {1'b0, count_q} - (WIDTH+1)'(DECREMENT_RATE);
    expire_d = diff_d[WIDTH] || (diff_d[WIDTH-1:0] == '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      per_q    <= 1'b0;
      done_q   <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      uf_q   <= 1'b0;
      if (load) begin
        count_q  <= load_val;
        reload_q <= load_val;
        per_q    <= periodic;
        state_q  <= (load_val != '0) ? RUN : IDLE;
      end else if (stop) begin
        state_q <= IDLE;
      end else if (state_q == RUN && en) begin
        if (expire_d) begin
          done_q  <= 1'b1;
          uf_q    <= diff_d[WIDTH];
          count_q <= per_q ? reload_q : '0;
          state_q <= per_q ? RUN : IDLE;
        end else begin
          count_q <= diff_d[WIDTH-1:0];
        end
      end
    end
  end
  assign count_val = count_q;
  assign running   = (state_q == RUN);
  assign done      = done_q;
  assign underflow = uf_q;
endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter: two counters (rate 1 and rate 3) driven in parallel, checked
// against an integer reference model through per-instance expectation queues.
module tb_down_counter;
  logic       clk = 1'b0;
  logic       rst = 1'b1, en = 1'b0, load = 1'b0, periodic = 1'b0, stop = 1'b0;
  logic [7:0] load_val = '0;
  logic [7:0] cv0, cv1;
  logic       r0, r1, d0, d1, u0, u1;
  int         total = 0, bad = 0;
  logic [10:0] q0[$], q1[$];
  int m_cnt[2], m_rel[2], m_per[2], m_run[2];
  int rates[2] = '{1, 3};

  always #5 clk = ~clk;

  down_counter #(.DECREMENT_RATE(1), .WIDTH(8)) dut0 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .periodic(periodic),
    .stop(stop), .count_val(cv0), .running(r0), .done(d0), .underflow(u0));
  down_counter #(.DECREMENT_RATE(3), .WIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .periodic(periodic),
    .stop(stop), .count_val(cv1), .running(r1), .done(d1), .underflow(u1));

  task automatic model_step(input int i, output logic [10:0] e);
    int dn = 0, uf = 0;
    if (rst) begin
      m_cnt[i] = 0; m_rel[i] = 0; m_per[i] = 0; m_run[i] = 0;
    end else if (load) begin
      m_cnt[i] = int'(load_val); m_rel[i] = int'(load_val);
      m_per[i] = int'(periodic); m_run[i] = (load_val != 0) ? 1 : 0;
    end else if (stop) begin
      m_run[i] = 0;
    end else if (m_run[i] == 1 && en) begin
      if (m_cnt[i] <= rates[i]) begin
        dn = 1;
        uf = (m_cnt[i] < rates[i]) ? 1 : 0;
        m_cnt[i] = (m_per[i] == 1) ? m_rel[i] : 0;
        m_run[i] = m_per[i];
      end else m_cnt[i] = m_cnt[i] - rates[i];
    end
    e = {m_cnt[i][7:0], m_run[i][0], dn[0], uf[0]};
  endtask

  task automatic cyc(input logic r, input logic e, input logic l, input logic [7:0] v,
                     input logic p, input logic s);
    logic [10:0] x0, x1;
    @(negedge clk);
    #1;
    rst = r; en = e; load = l; load_val = v; periodic = p; stop = s;
    model_step(0, x0); q0.push_back(x0);
    model_step(1, x1); q1.push_back(x1);
  endtask

  task automatic check(input int i, input logic [10:0] exp_v, input logic [10:0] got);
    total += 4;
    if (got[10:3] !== exp_v[10:3]) begin
      bad++; $display("FAIL count_val dut%0d got=%0d exp=%0d at %0t", i, got[10:3], exp_v[10:3], $time);
    end
    if (got[2] !== exp_v[2]) begin
      bad++; $display("FAIL running dut%0d got=%b exp=%b at %0t", i, got[2], exp_v[2], $time);
    end
    if (got[1] !== exp_v[1]) begin
      bad++; $display("FAIL done dut%0d got=%b exp=%b at %0t", i, got[1], exp_v[1], $time);
    end
    if (got[0] !== exp_v[0]) begin
      bad++; $display("FAIL underflow dut%0d got=%b exp=%b at %0t", i, got[0], exp_v[0], $time);
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) check(0, q0.pop_front(), {cv0, r0, d0, u0});
    if (q1.size() > 0) check(1, q1.pop_front(), {cv1, r1, d1, u1});
  end

  initial begin
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 8'h37, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 5, 0, 0);
    for (int k = 0; k < 7; k++) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 3, 1, 0);
    for (int k = 0; k < 8; k++) cyc(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 7, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 6, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 2, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 9, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 4, 0, 0);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 8'hff, 1, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 400; k++) begin
      logic [7:0] v;
      v = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 8, v,
          1'($urandom_range(0, 1)), $urandom_range(0, 99) < 4);
    end
    @(negedge clk);
    #2;
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++; $display("FAIL drain q0=%0d q1=%0d exp=0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
- Loadable down counter/timer: the decrementing counterpart to the generic up counter in generic_cells.
- Counts a loaded value down toward zero at DECREMENT_RATE per enabled cycle.
- Flags expiry with a one-cycle done pulse, and flags borrow past zero with an underflow pulse.
- Supports one-shot and periodic (auto-reload) modes; used for core timeouts, delay generation and periodic tick sources.

Parameters:
- DECREMENT_RATE, 1, amount subtracted per enabled cycle; legal range 1..2^WIDTH-1.
- WIDTH, 8, counter width in bits.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  count enable; decrement occurs only when en=1 and state is RUN
- load  input  1  load strobe; captures load_val and starts counting
- load_val  input  WIDTH  start value, also stored as reload value
- periodic  input  1  sampled with load: 1 = auto-reload on expiry, 0 = one-shot
- stop  input  1  abort; returns to IDLE, count_val holds
- count_val  output  WIDTH  current count
- running  output  1  1 while state is RUN
- done  output  1  one-cycle pulse on the cycle after expiry
- underflow  output  1  one-cycle pulse, coincident with done, when the decrement borrowed past zero

Behaviour:
- Reset: rst sampled high at a clk edge forces count_val=0, reload register=0, periodic mode register=0, state=IDLE, running=0, done=0, underflow=0. Reset has priority over all other inputs and aborts any count in progress.
- States:
  - IDLE: count_val holds.
  - RUN: counting.
- Arithmetic:
  - diff = {1'b0,count_val} - DECREMENT_RATE, WIDTH+1 bits.
  - borrow = diff[WIDTH].
  - Expiry when en=1 in RUN and (borrow=1 or diff[WIDTH-1:0]=0).
- Input priority per cycle: rst > load > stop > decrement.
- load=1:
  - count_val <= load_val; reload register <= load_val; mode register <= periodic.
  - State <= RUN if load_val != 0.
  - If load_val = 0: state <= IDLE, no done pulse.
  - Load in RUN restarts the count; a pending expiry that cycle is discarded (no done pulse).
- stop=1 (no load): state <= IDLE, count_val unchanged, no done pulse.
- RUN, en=1, no expiry: count_val <= diff[WIDTH-1:0].
- RUN, en=1, expiry:
  - done <= 1 for exactly one cycle.
  - underflow <= borrow.
  - Periodic mode: count_val <= reload register, state stays RUN.
  - One-shot mode: count_val <= 0, state <= IDLE.
- RUN, en=0: count_val holds, no events.
- done and underflow are registered: they are high in the cycle after the expiring edge, low otherwise.
- running reflects the state register directly (registered, no combinational path from inputs).
- Expiry period: a loaded value N gives done after ceil(N/DECREMENT_RATE) enabled cycles.

Test Plan:
- Reset: apply rst mid-count (WIDTH=8, count_val=0x37, RUN) -> next edge count_val=0, running=0, done=0, underflow=0; all stay put with en=1 and no load.
- One-shot, DECREMENT_RATE=1: load_val=5, periodic=0, en=1 continuously -> count_val 5,4,3,2,1,0; done high one cycle together with count_val=0; running=0 after; underflow=0.
- Periodic, DECREMENT_RATE=1: load_val=3, periodic=1, en=1 -> done pulses every 3 enabled cycles; count_val 3,2,1,3,2,1...; running stays 1. Deassert en for 4 cycles mid-count -> count_val frozen, no done.
- Underflow, DECREMENT_RATE=3: load_val=7, one-shot -> count_val 7,4,1, then expiry; done=1 and underflow=1 on the same cycle; count_val=0.
- Exact hit, DECREMENT_RATE=3: load_val=6 -> count_val 6,3, then expiry with done=1, underflow=0.
- Priority: load_val=9 asserted on the same edge as an expiring decrement -> count_val=9, no done pulse. stop with en=1 at count 4 -> count_val=4, running=0. load with load_val=0 -> running=0, no done pulse.
